// File: rtl/packet_queue.sv
// Single-clock packet FIFO: frames are written speculatively and only become
// readable once their last beat commits; overflowing or oversize frames are rewound.
module packet_queue #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DATA_DEPTH  = 4096,
    parameter int unsigned MAX_PACKETS = 32,
    parameter int unsigned MAX_PKT_LEN = 2047,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned LEN_W      = $clog2(MAX_PKT_LEN + 1),
    localparam int unsigned PC_W       = $clog2(MAX_PACKETS + 1)
) (
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic [LEN_W-1:0]      o_len,
    output logic [PC_W-1:0]       o_pkt_count,
    output logic                  o_drop,
    output logic [CNT_W-1:0]      o_drop_count
);

    localparam int unsigned AW      = $clog2(DATA_DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned DESC_AW = $clog2(MAX_PACKETS);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RECV,
        WR_DROP
    } wr_state_t;

    wr_state_t state;
    wr_state_t state_n;

    logic [DATA_WIDTH-1:0] mem      [DATA_DEPTH];
    logic [LEN_W-1:0]      desc_len [MAX_PACKETS];

    logic [PW-1:0]      spec_ptr;
    logic [PW-1:0]      spec_ptr_n;
    logic [PW-1:0]      commit_ptr;
    logic [PW-1:0]      fetch_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   count_n;
    logic [DESC_AW-1:0] desc_wr;
    logic [DESC_AW-1:0] f_idx;
    logic [LEN_W-1:0]   f_beat;
    logic [LEN_W-1:0]   f_len;
    logic               f_last;
    logic [PC_W-1:0]    pkt_count_n;

    logic                  accept;
    logic                  ram_full;
    logic                  wr_en;
    logic                  commit;
    logic                  drop;
    logic                  in_ready_n;
    logic                  readable;
    logic                  consume;
    logic                  pop;
    logic                  load_out;
    logic                  rd_en;
    logic                  ram_valid;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_last;
    logic [LEN_W-1:0]      ram_len;

    assign accept   = i_valid & o_in_ready;
    // Pointers equal except for the wrap bit means every entry holds unread data.
    assign ram_full = (spec_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};

    // Write FSM state register
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= WR_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Write FSM next state, speculative write and commit/drop decisions
    always_comb begin
        state_n    = state;
        spec_ptr_n = spec_ptr;
        count_n    = count;
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop       = 1'b0;
        case (state)
            WR_IDLE: begin
                if (accept) begin
                    if (ram_full) begin
                        if (i_last) begin
                            drop = 1'b1;
                        end else begin
                            state_n = WR_DROP;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        spec_ptr_n = spec_ptr + PW'(1);
                        count_n    = LEN_W'(1);
                        if (i_last) begin
                            commit = 1'b1;
                        end else begin
                            state_n = WR_RECV;
                        end
                    end
                end
            end
            WR_RECV: begin
                if (accept) begin
                    if (ram_full || (count == LEN_W'(MAX_PKT_LEN))) begin
                        spec_ptr_n = commit_ptr;
                        if (i_last) begin
                            drop    = 1'b1;
                            state_n = WR_IDLE;
                        end else begin
                            state_n = WR_DROP;
                        end
                    end else begin
                        wr_en      = 1'b1;
                        spec_ptr_n = spec_ptr + PW'(1);
                        count_n    = count + LEN_W'(1);
                        if (i_last) begin
                            commit  = 1'b1;
                            state_n = WR_IDLE;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (accept && i_last) begin
                    drop    = 1'b1;
                    state_n = WR_IDLE;
                end
            end
            default: begin
                state_n = WR_IDLE;
            end
        endcase
    end

    // Read-side pipeline: RAM register stage feeding the output register
    assign readable    = fetch_ptr != commit_ptr;
    assign consume     = o_valid & i_ready;
    assign pop         = consume & o_last;
    assign load_out    = ram_valid & (~o_valid | i_ready);
    assign rd_en       = readable & (~ram_valid | load_out);
    assign f_len       = desc_len[f_idx];
    assign f_last      = f_beat == f_len;
    assign pkt_count_n = o_pkt_count + PC_W'(commit) - PC_W'(pop);
    // Descriptor fullness only blocks the first beat of a new packet.
    assign in_ready_n  = (state_n != WR_IDLE) || (pkt_count_n != PC_W'(MAX_PACKETS));

    // Write-side pointers, descriptors and status outputs
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            spec_ptr     <= '0;
            commit_ptr   <= '0;
            count        <= '0;
            desc_wr      <= '0;
            o_in_ready   <= 1'b0;
            o_drop       <= 1'b0;
            o_drop_count <= '0;
            o_pkt_count  <= '0;
            for (int i = 0; i < int'(MAX_PACKETS); i++) begin
                desc_len[i] <= '0;
            end
        end else begin
            spec_ptr    <= spec_ptr_n;
            count       <= count_n;
            o_in_ready  <= in_ready_n;
            o_drop      <= drop;
            o_pkt_count <= pkt_count_n;
            if (commit) begin
                commit_ptr       <= spec_ptr_n;
                desc_len[desc_wr] <= count_n;
                desc_wr          <= desc_wr + DESC_AW'(1);
            end
            if (drop && (o_drop_count != {CNT_W{1'b1}})) begin
                o_drop_count <= o_drop_count + CNT_W'(1);
            end
        end
    end

    // Payload RAM with registered read port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[spec_ptr[AW-1:0]] <= i_data;
        end
        if (rd_en) begin
            ram_data <= mem[fetch_ptr[AW-1:0]];
        end
    end

    // Fetch tracking, output register and consumption pointer
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fetch_ptr <= '0;
            rd_ptr    <= '0;
            f_idx     <= '0;
            f_beat    <= LEN_W'(1);
            ram_valid <= 1'b0;
            ram_last  <= 1'b0;
            ram_len   <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_last    <= 1'b0;
            o_len     <= '0;
        end else begin
            if (rd_en) begin
                fetch_ptr <= fetch_ptr + PW'(1);
                ram_last  <= f_last;
                ram_len   <= f_len;
                if (f_last) begin
                    f_idx  <= f_idx + DESC_AW'(1);
                    f_beat <= LEN_W'(1);
                end else begin
                    f_beat <= f_beat + LEN_W'(1);
                end
            end
            ram_valid <= rd_en | (ram_valid & ~load_out);
            if (load_out) begin
                o_valid <= 1'b1;
                o_data  <= ram_data;
                o_last  <= ram_last;
                o_len   <= ram_len;
            end else if (consume) begin
                o_valid <= 1'b0;
            end
            // Space is released only when a beat is consumed, not when prefetched.
            if (consume) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_packet_queue.sv
// Scoreboard bench for packet_queue: a queue-based packet model predicts commits,
// drops, occupancy and handshakes; a separate monitor checks every consumed beat.
module tb_packet_queue;

    localparam int unsigned DW   = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXP = 4;
    localparam int unsigned MAXL = 6;
    localparam int unsigned CW   = 4;
    localparam int unsigned LW   = $clog2(MAXL + 1);
    localparam int unsigned PCW  = $clog2(MAXP + 1);

    logic           clk = 1'b0;
    logic           i_reset_n;
    logic           i_valid;
    logic           o_in_ready;
    logic [DW-1:0]  i_data;
    logic           i_last;
    logic           o_valid;
    logic           i_ready;
    logic [DW-1:0]  o_data;
    logic           o_last;
    logic [LW-1:0]  o_len;
    logic [PCW-1:0] o_pkt_count;
    logic           o_drop;
    logic [CW-1:0]  o_drop_count;

    packet_queue #(
        .DATA_WIDTH (DW),
        .DATA_DEPTH (DEPTH),
        .MAX_PACKETS(MAXP),
        .MAX_PKT_LEN(MAXL),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_valid     (i_valid),
        .o_in_ready  (o_in_ready),
        .i_data      (i_data),
        .i_last      (i_last),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_len       (o_len),
        .o_pkt_count (o_pkt_count),
        .o_drop      (o_drop),
        .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            len;
    } beat_t;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;

    beat_t         exp_q[$];
    int            pk_len_q[$];
    logic [DW-1:0] cur[$];
    int            occ_c;
    int            occ_pre;
    int            head_done;
    bit            acc;
    bit            dropping;
    bit            exp_drop;
    bit            exp_ready;
    int            exp_dcnt;
    beat_t         mb;
    beat_t         eb;
    bit            stall_prev;
    logic [DW+LW:0] held;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Back-pressure driver, changes only just after the active edge
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       i_ready = 1'b0;
            1:       i_ready = 1'b1;
            default: i_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Reference model: packet-level bookkeeping for the coming edge
    always @(negedge clk) begin
        if (!i_reset_n) begin
            exp_q.delete();
            pk_len_q.delete();
            cur.delete();
            occ_c     = 0;
            head_done = 0;
            dropping  = 1'b0;
            exp_drop  = 1'b0;
            exp_ready = 1'b0;
            exp_dcnt  = 0;
        end else begin
            chk("in_ready", o_in_ready, exp_ready);
            chk("pkt_count", o_pkt_count, pk_len_q.size());
            chk("drop_pulse", o_drop, exp_drop);
            chk("drop_count", o_drop_count, exp_dcnt);
            occ_pre  = occ_c;
            acc      = i_valid && o_in_ready;
            exp_drop = 1'b0;
            if (o_valid && i_ready && pk_len_q.size() > 0) begin
                occ_c--;
                head_done++;
                if (head_done == pk_len_q[0]) begin
                    void'(pk_len_q.pop_front());
                    head_done = 0;
                end
            end
            if (acc) begin
                if (dropping) begin
                    if (i_last) begin
                        dropping = 1'b0;
                        exp_drop = 1'b1;
                    end
                end else if ((occ_pre + cur.size() == DEPTH) || (cur.size() == MAXL)) begin
                    cur.delete();
                    if (i_last) exp_drop = 1'b1;
                    else dropping = 1'b1;
                end else begin
                    cur.push_back(i_data);
                    if (i_last) begin
                        for (int k = 0; k < cur.size(); k++) begin
                            mb.data = cur[k];
                            mb.last = (k == cur.size() - 1);
                            mb.len  = cur.size();
                            exp_q.push_back(mb);
                        end
                        pk_len_q.push_back(cur.size());
                        occ_c += cur.size();
                        cur.delete();
                    end
                end
            end
            if (exp_drop && exp_dcnt != (1 << CW) - 1) exp_dcnt++;
            exp_ready = dropping || (cur.size() > 0) || (pk_len_q.size() != MAXP);
        end
    end

    // Output monitor: pops the scoreboard on every consumed beat
    always @(negedge clk) begin
        if (!i_reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_payload", {o_data, o_last, o_len}, held);
            end
            if (o_valid) chk("valid_has_pkt", o_valid, exp_q.size() != 0);
            if (o_valid && i_ready && exp_q.size() > 0) begin
                eb = exp_q.pop_front();
                chk("beat_data", o_data, eb.data);
                chk("beat_last", o_last, eb.last);
                chk("beat_len", o_len, eb.len);
            end
            stall_prev = o_valid && !i_ready;
            held       = {o_data, o_last, o_len};
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [DW-1:0] d, input logic l);
        int g = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        @(negedge clk);
        while (!o_in_ready && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (!o_in_ready) begin
            chk("in_ready_timeout", o_in_ready, 1);
            i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++) put(DW'($urandom), i == len - 1);
    endtask

    task automatic drain();
        int g = 0;
        rdy_mode = 1;
        while ((o_pkt_count != 0 || exp_q.size() != 0) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_pkt_count", o_pkt_count, 0);
        align();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_in_ready"}, o_in_ready, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_last"}, o_last, 0);
        chk({tag, "_len"}, o_len, 0);
        chk({tag, "_pkt_count"}, o_pkt_count, 0);
        chk({tag, "_drop"}, o_drop, 0);
        chk({tag, "_drop_count"}, o_drop_count, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int run;
        int g;
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_last    = 1'b0;
        i_ready   = 1'b0;
        rdy_mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        i_reset_n = 1'b1;
        align();

        // Single-beat packet latency and contents
        rdy_mode = 1;
        align();
        put(8'hA5, 1'b1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!o_valid && cyc < 20);
        chk("first_latency", cyc, 3);
        chk("first_len", o_len, 1);
        chk("first_last", o_last, 1);
        chk("first_data", o_data, 8'hA5);
        chk("first_pkt_count", o_pkt_count, 1);
        @(negedge clk);
        chk("first_pkt_count_after", o_pkt_count, 0);
        drain();

        // Lengths 3,1,5 queued, then streamed without bubbles
        rdy_mode = 0;
        send_pkt(3);
        send_pkt(1);
        send_pkt(5);
        repeat (4) @(negedge clk);
        rdy_mode = 1;
        g = 0;
        while (!(o_valid && i_ready) && g < 50) begin
            @(negedge clk);
            g++;
        end
        run = 0;
        while (o_valid && i_ready && run < 20) begin
            run++;
            @(negedge clk);
        end
        chk("stream_run", run, 9);
        drain();

        // RAM overflow: two unread 6-beat packets, third overflows
        rdy_mode = 0;
        send_pkt(6);
        send_pkt(6);
        send_pkt(6);
        repeat (2) @(negedge clk);
        chk("ovf_drop_count", o_drop_count, 1);
        chk("ovf_pkt_count", o_pkt_count, 2);
        drain();

        // Oversize packet dropped, maximum-length packet kept
        rdy_mode = 0;
        send_pkt(MAXL + 2);
        send_pkt(MAXL);
        repeat (4) @(negedge clk);
        chk("maxlen_drop_count", o_drop_count, 2);
        chk("maxlen_valid", o_valid, 1);
        chk("maxlen_len", o_len, MAXL);
        drain();

        // Descriptor queue full blocks the next first beat
        rdy_mode = 0;
        for (int p = 0; p < MAXP; p++) send_pkt(1);
        fork
            put(8'h3C, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("desc_full_ready", o_in_ready, 0);
                end
                rdy_mode = 1;
            end
        join
        drain();

        // Randomized traffic with random back-pressure
        rdy_mode = 2;
        for (int p = 0; p < 250; p++) begin
            send_pkt($urandom_range(1, MAXL + 2));
            repeat ($urandom_range(0, 2)) align();
        end
        drain();

        // Reset in the middle of a partial write and a stalled read
        rdy_mode = 0;
        send_pkt(3);
        put(8'h11, 1'b0);
        put(8'h22, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_pkt_count", o_pkt_count, 0);
        chk("post_reset_valid", o_valid, 0);
        align();
        send_pkt(2);
        drain();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
